// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-client round-robin arbiter with registered one-hot grant and optional hold limit
module rr_arbiter8 #(
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] GNT_IDX,
    output logic       VALID
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] CNT_MAX  = '1;
    localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);

    state_t            state, state_nxt;
    logic [7:0]        gnt_q, gnt_nxt;
    logic              valid_q, valid_nxt;
    logic [2:0]        ptr, ptr_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [2:0]        owner;
    logic [7:0]        cand;
    logic [2:0]        arb_ptr;
    logic [3:0]        win;
    logic              release_now;

    // Returns {found, index}; scanning from the far end lets the slot nearest p win.
    function automatic logic [3:0] arbitrate(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] k;
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (v[k]) r = {1'b1, k};
        end
        return r;
    endfunction

    // Index is the OR-encode of the registered one-hot grant, so it is zero when idle.
    assign owner = {gnt_q[4] | gnt_q[5] | gnt_q[6] | gnt_q[7],
                    gnt_q[2] | gnt_q[3] | gnt_q[6] | gnt_q[7],
                    gnt_q[1] | gnt_q[3] | gnt_q[5] | gnt_q[7]};

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_q;
        valid_nxt   = valid_q;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        cand        = REQ;
        arb_ptr     = ptr;
        release_now = 1'b0;

        if (state == GRANT) begin
            release_now = !REQ[owner] || ((MAX_HOLD != 0) && (cnt == HOLD_LIM));
            cand        = REQ & ~gnt_q;
            arb_ptr     = owner + 3'd1;
        end

        win = arbitrate(cand, arb_ptr);

        if (state == IDLE || release_now) begin
            if (release_now) ptr_nxt = owner + 3'd1;
            if (win[3]) begin
                state_nxt = GRANT;
                gnt_nxt   = 8'b1 << win[2:0];
                valid_nxt = 1'b1;
                cnt_nxt   = CNT_ONE;
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = 8'h00;
                valid_nxt = 1'b0;
                cnt_nxt   = '0;
            end
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
            ptr     <= 3'd0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            valid_q <= valid_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign GNT     = gnt_q;
    assign GNT_IDX = owner;
    assign VALID   = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed and randomised checks of rr_arbiter8 in unlimited, 4-cycle and 3-cycle hold builds
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req0, req4, req3;
    logic [7:0] gnt0, gnt4, gnt3;
    logic [2:0] idx0, idx4, idx3;
    logic       vld0, vld4, vld3;

    int checks;
    int errors;
    int waitc[2][8];
    int max_wait;

    rr_arbiter8 #(.MAX_HOLD(0), .HOLD_W(8)) dut0 (
        .CLK(clk), .RESET(rst), .REQ(req0), .GNT(gnt0), .GNT_IDX(idx0), .VALID(vld0));
    rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) dut4 (
        .CLK(clk), .RESET(rst), .REQ(req4), .GNT(gnt4), .GNT_IDX(idx4), .VALID(vld4));
    rr_arbiter8 #(.MAX_HOLD(3), .HOLD_W(8)) dut3 (
        .CLK(clk), .RESET(rst), .REQ(req3), .GNT(gnt3), .GNT_IDX(idx3), .VALID(vld3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [2:0] enc(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [7:0] rand_req();
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'h01 << $urandom_range(0, 7);
        return 8'($urandom) | 8'($urandom);
    endfunction

    task automatic inv(input int d, input logic [7:0] g, input logic [2:0] ix, input logic v,
                       input logic [7:0] r, input logic [7:0] pg);
        logic newg;
        check("onehot", 32'((g & (g - 8'd1)) == 8'h00), 32'd1);
        check("idx_enc", 32'(ix), 32'(enc(g)));
        check("valid_or", 32'(v), 32'(|g));
        check("gnt_req", 32'((g & ~r) == 8'h00), 32'd1);
        newg = (g != 8'h00) && (g != pg);
        for (int c = 0; c < 8; c++) begin
            if (!r[c]) waitc[d][c] = 0;
            else if (newg && g[c]) waitc[d][c] = 0;
            else if (newg) waitc[d][c]++;
            if (waitc[d][c] > max_wait) max_wait = waitc[d][c];
        end
    endtask

    initial begin
        logic [7:0] exp_g;
        logic [7:0] r0, r3, pg0, pg3;
        int w;
        checks   = 0;
        errors   = 0;
        max_wait = 0;
        rst  = 1'b0;
        req0 = 8'h00;
        req4 = 8'h00;
        req3 = 8'h00;

        // idle and first-grant latency
        do_reset();
        check("rst_gnt", 32'(gnt0), 32'h00);
        check("rst_idx", 32'(idx0), 32'h0);
        check("rst_valid", 32'(vld0), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_valid", 32'(vld0), 32'h0);
        end
        req0 = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("lat_gnt", 32'(gnt0), 32'h01);
            check("lat_idx", 32'(idx0), 32'h0);
            check("lat_valid", 32'(vld0), 32'h1);
        end
        req0 = 8'h00;
        tick();
        check("drop_gnt", 32'(gnt0), 32'h00);
        check("drop_valid", 32'(vld0), 32'h0);

        // rotation with wrap, no bubbles
        do_reset();
        req0 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            w = i % 8;
            check("rot_gnt", 32'(gnt0), 32'h1 << w);
            check("rot_idx", 32'(idx0), 32'(w));
            check("rot_valid", 32'(vld0), 32'h1);
            req0 = 8'hFF & ~(8'h01 << w);
        end

        // pointer past client 4 skips to 0 first
        do_reset();
        req0 = 8'h10;
        tick();
        check("skip_g4", 32'(gnt0), 32'h10);
        req0 = 8'h00;
        tick();
        check("skip_idle", 32'(vld0), 32'h0);
        req0 = 8'h11;
        tick();
        check("skip_gnt0", 32'(gnt0), 32'h01);
        check("skip_idx0", 32'(idx0), 32'h0);
        req0 = 8'h10;
        tick();
        check("skip_gnt4", 32'(gnt0), 32'h10);
        check("skip_idx4", 32'(idx0), 32'h4);

        // reset mid-grant
        do_reset();
        req0 = 8'h40;
        tick();
        check("mid_g6", 32'(gnt0), 32'h40);
        rst  = 1'b1;
        req0 = 8'h84;
        tick();
        check("mid_rst_gnt", 32'(gnt0), 32'h00);
        check("mid_rst_idx", 32'(idx0), 32'h0);
        check("mid_rst_valid", 32'(vld0), 32'h0);
        rst = 1'b0;
        tick();
        check("mid_gnt", 32'(gnt0), 32'h04);
        check("mid_idx", 32'(idx0), 32'h2);

        // hold limit 4: alternate 0 and 2 without gaps
        do_reset();
        req4 = 8'h05;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_g = ((i / 4) % 2 == 0) ? 8'h01 : 8'h04;
            check("hold_gnt", 32'(gnt4), 32'(exp_g));
            check("hold_idx", 32'(idx4), 32'(enc(exp_g)));
        end

        // hold limit 4, sole requester: one idle cycle between grants
        do_reset();
        req4 = 8'h08;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp_g = (i % 5 < 4) ? 8'h08 : 8'h00;
            check("sole_gnt", 32'(gnt4), 32'(exp_g));
            check("sole_valid", 32'(vld4), 32'(exp_g != 8'h00));
        end
        req4 = 8'h00;

        // randomised invariants, unlimited and 3-cycle hold builds
        do_reset();
        for (int d = 0; d < 2; d++) for (int c = 0; c < 8; c++) waitc[d][c] = 0;
        for (int n = 0; n < 10000; n++) begin
            r0   = rand_req();
            r3   = rand_req();
            pg0  = gnt0;
            pg3  = gnt3;
            req0 = r0;
            req3 = r3;
            tick();
            inv(0, gnt0, idx0, vld0, r0, pg0);
            inv(1, gnt3, idx3, vld3, r3, pg3);
        end
        check("starve", 32'(max_wait <= 8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
